// File: rtl/audio_dac_tx.sv
// -----------------------------------------------------------------------------
// audio_dac_tx
//
// Serial transmitter for a DAC121S101-style DAC (Pmod DA2 wiring).
// Takes one 12-bit sample per valid/ready handshake and shifts out one
// 16-bit frame {2'b00, pd, sample} MSB first. The DAC samples DIN on the
// falling edge of SCLK. SYNC is held high for GAP_CYCLES between frames.
//
// Parameters:
//   CLK_DIV     CLOCK cycles per SCLK half-period (>= 1)
//   GAP_CYCLES  CLOCK cycles SYNC stays high between frames (>= 1)
//
// Ports:
//   CLOCK         system clock
//   RESET         asynchronous, active-high reset
//   sample[11:0]  unsigned sample to transmit
//   pd[1:0]       DAC power-down bits (00 = normal operation)
//   sample_valid  producer offers a sample
//   sample_ready  block can accept a sample (registered)
//   busy          frame or inter-frame gap in progress (registered)
//   frame_done    one-cycle pulse in the cycle SYNC returns high (registered)
//   dac_sync_n    DAC SYNC, active low (registered)
//   dac_sclk      DAC serial clock, idles high (registered)
//   dac_din       DAC serial data, MSB first (registered)
// -----------------------------------------------------------------------------
module audio_dac_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [11:0] sample,
  input  logic [1:0]  pd,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO  = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  // 32 SCLK half-periods per frame; the last one closes the frame.
  localparam logic [4:0]       HALF_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_cnt_s;
  logic [4:0]       half_cnt_r;
  logic [4:0]       half_cnt_s;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [GAP_W-1:0] gap_cnt_s;
  // Holds the 15 bits still to be presented; bit 15 goes straight to DIN.
  logic [14:0]      shreg_r;
  logic [14:0]      shreg_s;

  logic ready_r;
  logic ready_s;
  logic busy_r;
  logic busy_s;
  logic done_r;
  logic done_s;
  logic sync_n_r;
  logic sync_n_s;
  logic sclk_r;
  logic sclk_s;
  logic din_r;
  logic din_s;

  logic        accept_s;
  logic        tick_s;
  logic        last_half_s;
  logic        gap_end_s;
  logic [15:0] frame_word_s;

  assign accept_s     = sample_valid && ready_r;
  assign tick_s       = (div_cnt_r == DIV_LAST);
  assign last_half_s  = (half_cnt_r == HALF_LAST);
  assign gap_end_s    = (gap_cnt_r == GAP_LAST);
  assign frame_word_s = {2'b00, pd, sample};

  assign sample_ready = ready_r;
  assign busy         = busy_r;
  assign frame_done   = done_r;
  assign dac_sync_n   = sync_n_r;
  assign dac_sclk     = sclk_r;
  assign dac_din      = din_r;

  // State register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (tick_s && last_half_s) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the datapath and of every (registered) output.
  always_comb begin
    div_cnt_s  = div_cnt_r;
    half_cnt_s = half_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    shreg_s    = shreg_r;
    ready_s    = ready_r;
    done_s     = 1'b0;
    sync_n_s   = sync_n_r;
    sclk_s     = sclk_r;
    din_s      = din_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          // Capture happens only here; later input changes are ignored.
          shreg_s    = frame_word_s[14:0];
          din_s      = frame_word_s[15];
          sync_n_s   = 1'b0;
          sclk_s     = 1'b1;
          ready_s    = 1'b0;
          div_cnt_s  = DIV_ZERO;
          half_cnt_s = 5'd0;
        end else begin
          ready_s    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (tick_s) begin
          div_cnt_s = DIV_ZERO;
          if (last_half_s) begin
            // Closing half-period after the 16th fall: end the frame.
            sclk_s    = 1'b1;
            sync_n_s  = 1'b1;
            din_s     = 1'b0;
            done_s    = 1'b1;
            gap_cnt_s = GAP_ZERO;
          end else if (!half_cnt_r[0]) begin
            // Even half index: falling edge, DIN already holds the bit.
            sclk_s     = 1'b0;
            half_cnt_s = half_cnt_r + 5'd1;
          end else begin
            // Odd half index: rising edge, advance DIN to the next bit.
            sclk_s     = 1'b1;
            din_s      = shreg_r[14];
            shreg_s    = {shreg_r[13:0], 1'b0};
            half_cnt_s = half_cnt_r + 5'd1;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end

      ST_GAP: begin
        if (gap_end_s) begin
          ready_s   = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_ONE;
        end
      end

      default: begin
        ready_s  = 1'b1;
        sync_n_s = 1'b1;
        sclk_s   = 1'b1;
        din_s    = 1'b0;
      end
    endcase

    busy_s = !ready_s;
  end

  // Datapath and output registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      div_cnt_r  <= DIV_ZERO;
      half_cnt_r <= 5'd0;
      gap_cnt_r  <= GAP_ZERO;
      shreg_r    <= 15'd0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sync_n_r   <= 1'b1;
      sclk_r     <= 1'b1;
      din_r      <= 1'b0;
    end else begin
      div_cnt_r  <= div_cnt_s;
      half_cnt_r <= half_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      shreg_r    <= shreg_s;
      ready_r    <= ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      sync_n_r   <= sync_n_s;
      sclk_r     <= sclk_s;
      din_r      <= din_s;
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_dac_tx
//
// Self-checking bench for audio_dac_tx. Two instances: defaults (CLK_DIV=4,
// GAP_CYCLES=8) and a fast one (CLK_DIV=1, GAP_CYCLES=1). A behavioural model
// derives every output from the time elapsed since the accepting edge; one
// compare process checks both instances on every falling CLOCK edge. Directed
// tests add hand-computed literal checks on bit patterns and timing.
// -----------------------------------------------------------------------------
module tb_audio_dac_tx;

  localparam int MD = 4;
  localparam int MG = 8;
  localparam int FD = 1;
  localparam int FG = 1;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [11:0] sample;
  logic [1:0]  pd;
  logic        sample_valid;
  logic        sample_ready, busy, frame_done, dac_sync_n, dac_sclk, dac_din;

  logic [11:0] f_sample;
  logic [1:0]  f_pd;
  logic        f_valid;
  logic        f_ready, f_busy, f_done, f_sync_n, f_sclk, f_din;

  audio_dac_tx #(.CLK_DIV(MD), .GAP_CYCLES(MG)) u_dut (
    .CLOCK(CLOCK), .RESET(RESET), .sample(sample), .pd(pd),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .frame_done(frame_done), .dac_sync_n(dac_sync_n), .dac_sclk(dac_sclk),
    .dac_din(dac_din)
  );

  audio_dac_tx #(.CLK_DIV(FD), .GAP_CYCLES(FG)) u_fast (
    .CLOCK(CLOCK), .RESET(RESET), .sample(f_sample), .pd(f_pd),
    .sample_valid(f_valid), .sample_ready(f_ready), .busy(f_busy),
    .frame_done(f_done), .dac_sync_n(f_sync_n), .dac_sclk(f_sclk),
    .dac_din(f_din)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected {ready, busy, frame_done, sync_n, sclk, din} at t edges after
  // the accepting edge. n counts SCLK half-periods elapsed: SCLK is high for
  // even n, DIN holds frame bit 15 - n/2.
  function automatic logic [5:0] exp_out(input int d, input bit act, input int t,
                                         input logic [15:0] w);
    int   n;
    logic sc;
    logic dn;
    if (!act) return 6'b100110;
    if (t < 32 * d) begin
      n  = t / d;
      sc = ((n % 2) == 0);
      dn = w[15 - n / 2];
      return {1'b0, 1'b1, 1'b0, 1'b0, sc, dn};
    end
    if (t == 32 * d) return 6'b011110;
    return 6'b010110;
  endfunction

  // Models: active from the accepting edge until 32*D+G edges later.
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [15:0] m_w = 16'h0;
  bit          f_act = 1'b0;
  int          f_t = 0;
  logic [15:0] f_w = 16'h0;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      m_act <= 1'b0;
      m_t   <= 0;
    end else if (m_act) begin
      m_t <= m_t + 1;
      if (m_t + 1 >= 32 * MD + MG) m_act <= 1'b0;
    end else if (sample_valid) begin
      m_act <= 1'b1;
      m_t   <= 0;
      m_w   <= {2'b00, pd, sample};
    end
  end

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      f_act <= 1'b0;
      f_t   <= 0;
    end else if (f_act) begin
      f_t <= f_t + 1;
      if (f_t + 1 >= 32 * FD + FG) f_act <= 1'b0;
    end else if (f_valid) begin
      f_act <= 1'b1;
      f_t   <= 0;
      f_w   <= {2'b00, f_pd, f_sample};
    end
  end

  // Bits as the DAC sees them: DIN at each SCLK falling edge.
  logic [15:0] m_bits = 16'h0;
  logic [15:0] f_bits = 16'h0;
  always @(negedge dac_sclk) m_bits <= {m_bits[14:0], dac_din};
  always @(negedge f_sclk)   f_bits <= {f_bits[14:0], f_din};

  // Monitor state, sampled on the falling CLOCK edge.
  int ncyc = 0;
  int acc_cnt = 0, acc_n = 0, acc_prev = 0;
  int done_cnt = 0, done_lat = 0;
  int ready_cnt = 0, ready_lat = 0;
  int low_run = 0, low_len = 0;
  bit ready_q = 1'b0;
  int f_acc_cnt = 0, f_acc_n = 0, f_acc_prev = 0;
  int f_low_run = 0, f_low_len = 0;
  int f_fall_n = 0, f_period = 0;
  bit f_sclk_q = 1'b1;

  // Compare process plus timing monitors.
  always @(negedge CLOCK) begin
    check("main_outputs", {26'd0, sample_ready, busy, frame_done, dac_sync_n, dac_sclk, dac_din},
          {26'd0, exp_out(MD, m_act, m_t, m_w)});
    check("fast_outputs", {26'd0, f_ready, f_busy, f_done, f_sync_n, f_sclk, f_din},
          {26'd0, exp_out(FD, f_act, f_t, f_w)});

    ncyc <= ncyc + 1;
    if (sample_valid && sample_ready) begin
      acc_prev <= acc_n;
      acc_n    <= ncyc;
      acc_cnt  <= acc_cnt + 1;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_lat <= ncyc - acc_n - 1;
    end
    if (sample_ready && !ready_q) begin
      ready_cnt <= ready_cnt + 1;
      ready_lat <= ncyc - acc_n - 1;
    end
    ready_q <= sample_ready;
    if (!dac_sync_n) begin
      low_run <= low_run + 1;
    end else begin
      if (low_run != 0) low_len <= low_run;
      low_run <= 0;
    end

    if (f_valid && f_ready) begin
      f_acc_prev <= f_acc_n;
      f_acc_n    <= ncyc;
      f_acc_cnt  <= f_acc_cnt + 1;
    end
    if (!f_sync_n) begin
      f_low_run <= f_low_run + 1;
    end else begin
      if (f_low_run != 0) f_low_len <= f_low_run;
      f_low_run <= 0;
    end
    if (!f_sclk && f_sclk_q) begin
      f_period <= ncyc - f_fall_n;
      f_fall_n <= ncyc;
    end
    f_sclk_q <= f_sclk;
  end

  // Offer one sample, wait for the accept, then scramble the inputs.
  task automatic send(input logic [11:0] s, input logic [1:0] p);
    int a0;
    a0 = acc_cnt;
    @(posedge CLOCK); #2;
    sample = s; pd = p; sample_valid = 1'b1;
    for (int i = 0; i < 400 && acc_cnt == a0; i++) @(negedge CLOCK);
    check("accept_seen", {31'd0, acc_cnt != a0}, 32'd1);
    @(posedge CLOCK); #2;
    sample_valid = 1'b0;
    sample = ~s; pd = ~p;
  endtask

  // Wait for the end of the gap, then check bits and timing of the frame.
  task automatic wait_frame(input string name, input logic [15:0] bits_exp);
    int d0;
    int r0;
    d0 = done_cnt;
    r0 = ready_cnt;
    for (int i = 0; i < 400 && ready_cnt == r0; i++) @(negedge CLOCK);
    check({name, "_ready_seen"}, {31'd0, ready_cnt != r0}, 32'd1);
    check({name, "_done_pulses"}, done_cnt - d0, 32'd1);
    check({name, "_bits"}, {16'd0, m_bits}, {16'd0, bits_exp});
    check({name, "_sync_low"}, low_len, 32'd128);
    check({name, "_done_lat"}, done_lat, 32'd128);
    check({name, "_ready_lat"}, ready_lat, 32'd136);
  endtask

  logic [15:0] cont_exp [3] = '{16'h0000, 16'h0001, 16'h0002};

  initial begin
    int base;
    int d0;
    RESET = 1'b1;
    sample = 12'h000; pd = 2'b00; sample_valid = 1'b0;
    f_sample = 12'h000; f_pd = 2'b00; f_valid = 1'b0;
    repeat (3) @(posedge CLOCK);
    #2;
    check("reset_values", {26'd0, sample_ready, busy, frame_done, dac_sync_n, dac_sclk, dac_din},
          32'b100110);
    RESET = 1'b0;
    repeat (3) @(posedge CLOCK);

    // Single frame 0xABC.
    send(12'hABC, 2'b00);
    wait_frame("abc", 16'h0ABC);

    // Power-down bits.
    send(12'h000, 2'b11);
    wait_frame("pd11", 16'h3000);

    // Continuous valid with incrementing sample.
    repeat (5) @(posedge CLOCK);
    base = acc_cnt;
    #2;
    sample = 12'h000; pd = 2'b00; sample_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 400 && acc_cnt < base + k + 1; i++) @(negedge CLOCK);
      check("cont_accept_seen", {31'd0, acc_cnt >= base + k + 1}, 32'd1);
      @(posedge CLOCK);
      if (k > 0) check("cont_interval", acc_n - acc_prev, 32'd137);
      #2;
      if (k == 2) sample_valid = 1'b0;
      else sample = 12'(k + 1);
      wait_frame("cont", cont_exp[k]);
    end

    // Reset in the middle of a frame.
    repeat (4) @(posedge CLOCK);
    send(12'hFFF, 2'b00);
    d0 = done_cnt;
    repeat (48) @(posedge CLOCK);
    #2;
    RESET = 1'b1;
    #1;
    check("midframe_reset", {26'd0, sample_ready, busy, frame_done, dac_sync_n, dac_sclk, dac_din},
          32'b100110);
    repeat (3) @(posedge CLOCK);
    #2;
    RESET = 1'b0;
    repeat (150) @(negedge CLOCK);
    check("no_done_after_reset", done_cnt, d0);
    send(12'h123, 2'b00);
    wait_frame("after_reset", 16'h0123);

    // Fast instance: CLK_DIV=1, GAP_CYCLES=1, back-to-back frames.
    base = f_acc_cnt;
    @(posedge CLOCK); #2;
    f_sample = 12'h555; f_pd = 2'b00; f_valid = 1'b1;
    for (int i = 0; i < 200 && f_acc_cnt < base + 2; i++) @(negedge CLOCK);
    check("fast_accepts_seen", {31'd0, f_acc_cnt >= base + 2}, 32'd1);
    @(posedge CLOCK); #2;
    f_valid = 1'b0;
    repeat (40) @(negedge CLOCK);
    check("fast_interval", f_acc_n - f_acc_prev, 32'd34);
    check("fast_bits", {16'd0, f_bits}, 32'h0555);
    check("fast_sync_low", f_low_len, 32'd32);
    check("fast_sclk_period", f_period, 32'd2);

    repeat (5) @(posedge CLOCK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/audio_dac_tx.md
# audio_dac_tx

Serial transmitter that drives a 12-bit audio sample out to an external SPI-style DAC (DAC121S101 framing, Pmod DA2 wiring: SYNC/SCLK/DIN). It is the output-direction counterpart of the microphone capture path: capture and processing logic hand it one sample per handshake, and it shifts out one 16-bit frame per sample on the JA/JB header pins. It sits beside the audio capture and display blocks under the top level.

## Interface
- CLK_DIV, default 4: CLOCK cycles per SCLK half-period (≥1); 100 MHz / (2·4) = 12.5 MHz SCLK.
- GAP_CYCLES, default 8: CLOCK cycles SYNC stays high between frames (≥1).
- CLOCK  input  1  system clock, 100 MHz.
- RESET  input  1  asynchronous, active-high reset.
- sample  input  12  unsigned sample to transmit.
- pd  input  2  DAC power-down mode bits; 00 = normal.
- sample_valid  input  1  producer has a sample.
- sample_ready  output  1  block can accept a sample.
- busy  output  1  frame or gap in progress.
- frame_done  output  1  one-cycle pulse when SYNC returns high.
- dac_sync_n  output  1  DAC SYNC, active low.
- dac_sclk  output  1  DAC serial clock, idles high.
- dac_din  output  1  DAC serial data, MSB first.

## Operation
- Frame word = {2'b00, pd[1:0], sample[11:0]}, 16 bits, MSB first; DAC samples DIN on SCLK falling edge.
- All outputs registered. Reset values: sample_ready=1, busy=0, frame_done=0, dac_sync_n=1, dac_sclk=1, dac_din=0.
- States: IDLE, SHIFT, GAP.
- IDLE: sample_ready=1. A transfer is accepted at a CLOCK edge with sample_valid && sample_ready. sample/pd are captured into the shift register at that edge only; later changes to them are ignored.
- SHIFT: SCLK toggles every CLK_DIV cycles. A falling edge presents the current bit. dac_din advances to the next bit on each rising edge except after the 16th falling edge.
- After the 16th falling edge plus CLK_DIV cycles: dac_sclk=1, dac_sync_n=1, dac_din=0, frame_done=1 for one cycle, then go to GAP.
- GAP: count GAP_CYCLES, then sample_ready=1 and go to IDLE.
- busy = !sample_ready.
- sample_valid while not ready has no effect. No buffering: at most one sample is in flight.

## Timing
- E0 = accepting edge. At E0: dac_sync_n←0, dac_din←bit15, sample_ready←0, busy←1; dac_sclk stays 1.
- k-th SCLK fall (k=1..16) at E0+(2k−1)·CLK_DIV, presenting bit 16−k. Rises at E0+2k·CLK_DIV for k=1..15, each with dac_din←next bit.
- At E0+32·CLK_DIV: dac_sclk←1, dac_sync_n←1, dac_din←0, frame_done←1.
- SYNC low for exactly 32·CLK_DIV cycles.
- At E0+32·CLK_DIV+GAP_CYCLES: sample_ready←1.
- Minimum accept-to-accept interval: 32·CLK_DIV+GAP_CYCLES+1 cycles (137 with defaults).
- DIN is stable for CLK_DIV cycles on each side of every SCLK falling edge.
- RESET mid-frame: all outputs return to reset values immediately (asynchronous). SYNC rises before the 16th fall, so the DAC discards the partial frame. No frame_done pulse.
- RESET released: the first accept is possible at the first edge with sample_valid.

## Test plan
- Single frame: sample=0xABC, pd=00, defaults. Required: 16 falling-edge DIN bits = 0000_1010_1011_1100; SYNC low 128 cycles; frame_done at E0+128; sample_ready at E0+136.
- Power-down bits: sample=0x000, pd=11. Required: falling-edge bits = 0011_0000_0000_0000.
- Continuous sample_valid=1 with an incrementing sample 0x000,0x001,0x002. Required: accepts exactly 137 cycles apart; each frame carries its own value; captured data is unaffected by the sample changing mid-frame.
- Reset at E0+50 during sample=0xFFF. Required: same-cycle sync_n=1, sclk=1, din=0, sample_ready=1; no frame_done; next sample=0x123 transmits correctly.
- CLK_DIV=1, GAP_CYCLES=1, sample=0x555. Required: SCLK period 2 cycles; SYNC low 32 cycles; bits 0000_0101_0101_0101; accept-to-accept 34 cycles.
